// File: rtl/resample_pkg.sv
// Shared types and width helpers for the polyphase L/M resampler sequencer.
package resample_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MAC,
    FLUSH,
    ADVANCE
  } state_t;

  localparam int DEF_NUMBER_OF_TAPS = 64;
  localparam int DEF_INTERP_L       = 4;
  localparam int DEF_DECIM_M        = 3;

  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  // Every polyphase branch must own the same number of prototype taps.
  function automatic bit taps_fit(input int taps, input int interp);
    return (interp > 0) && ((taps % interp) == 0);
  endfunction

  localparam int DEF_PHASE_W = clog2_min1(DEF_INTERP_L);
  localparam int DEF_TAP_W   = clog2_min1(DEF_NUMBER_OF_TAPS / DEF_INTERP_L);
  localparam int DEF_CADDR_W = clog2_min1(DEF_NUMBER_OF_TAPS);
  localparam int DEF_NEED_W  = clog2_min1(DEF_DECIM_M / DEF_INTERP_L + 2);

endpackage

// File: rtl/resample_phase_stepper.sv
// Polyphase phase accumulator plus count of input samples still owed to the delay line.
module resample_phase_stepper #(
  parameter int INTERP_L = 4,
  parameter int DECIM_M  = 3,
  parameter int PHASE_W  = 2,
  parameter int NEED_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               sub_en,
  input  logic               consume,
  output logic [PHASE_W-1:0] phase,
  output logic [NEED_W-1:0]  need_cnt,
  output logic               sub_done
);

  // Extra headroom so phase + DECIM_M never wraps before it is folded back below L.
  localparam int PH_W = PHASE_W + NEED_W + 1;
  localparam logic [PH_W-1:0] L_STEP = PH_W'(INTERP_L);
  localparam logic [PH_W-1:0] M_STEP = PH_W'(DECIM_M);

  logic [PH_W-1:0] phase_acc;

  assign sub_done = (phase_acc < L_STEP);
  assign phase    = phase_acc[PHASE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      need_cnt  <= NEED_W'(1);
    end else if (step) begin
      phase_acc <= phase_acc + M_STEP;
    end else if (sub_en && !sub_done) begin
      phase_acc <= phase_acc - L_STEP;
      need_cnt  <= need_cnt + NEED_W'(1);
    end else if (consume) begin
      need_cnt  <= need_cnt - NEED_W'(1);
    end
  end

endmodule

// File: rtl/resample_mac_sequencer.sv
// Control FSM for the polyphase L/M resampler: fetch inputs, run one MAC per tap, flush, advance phase.
module resample_mac_sequencer
  import resample_pkg::*;
#(
  parameter  int NUMBER_OF_TAPS = DEF_NUMBER_OF_TAPS,
  parameter  int INTERP_L       = DEF_INTERP_L,
  parameter  int DECIM_M        = DEF_DECIM_M,
  localparam int TAPS_PER_PHASE = NUMBER_OF_TAPS / INTERP_L,
  localparam int PHASE_W        = clog2_min1(INTERP_L),
  localparam int TAP_W          = clog2_min1(TAPS_PER_PHASE),
  localparam int CADDR_W        = clog2_min1(NUMBER_OF_TAPS),
  localparam int NEED_W         = clog2_min1(DECIM_M / INTERP_L + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [TAP_W-1:0]   rd_offset,
  output logic [CADDR_W-1:0] coeff_addr,
  output logic               mac_en,
  output logic               phase_min,
  output logic               out_valid,
  output logic               busy
);

  if (!taps_fit(NUMBER_OF_TAPS, INTERP_L)) begin : g_bad_taps
    $error("NUMBER_OF_TAPS must be a multiple of INTERP_L");
  end

  localparam logic [TAP_W-1:0]   K_LAST    = TAP_W'(TAPS_PER_PHASE - 1);
  localparam logic [CADDR_W-1:0] ADDR_STEP = CADDR_W'(INTERP_L);

  state_t               state, state_nxt;
  logic [TAP_W-1:0]     k;
  logic [CADDR_W-1:0]   addr;
  logic [PHASE_W-1:0]   phase;
  logic [NEED_W-1:0]    need_cnt;
  logic                 sub_done;

  resample_phase_stepper #(
    .INTERP_L (INTERP_L),
    .DECIM_M  (DECIM_M),
    .PHASE_W  (PHASE_W),
    .NEED_W   (NEED_W)
  ) u_stepper (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (state == FLUSH),
    .sub_en   (state == ADVANCE),
    .consume  (wr_en),
    .phase    (phase),
    .need_cnt (need_cnt),
    .sub_done (sub_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outside MAC the tap counter parks at 0 and the address preloads the phase,
  // so the first tap needs no special case; each tap then steps by L.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      addr      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == FLUSH);
      if (state == MAC) begin
        k    <= k + TAP_W'(1);
        addr <= addr + ADDR_STEP;
      end else begin
        k    <= '0;
        addr <= CADDR_W'(phase);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    rd_offset  = '0;
    coeff_addr = '0;
    mac_en     = 1'b0;
    phase_min  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) begin
          state_nxt = (need_cnt != '0) ? FETCH : MAC;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        if (in_valid && (need_cnt == NEED_W'(1))) begin
          state_nxt = MAC;
        end
      end
      MAC: begin
        mac_en     = 1'b1;
        rd_offset  = k;
        coeff_addr = addr;
        phase_min  = (k == '0);
        if (k == K_LAST) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        phase_min = 1'b1;
        state_nxt = ADVANCE;
      end
      ADVANCE: begin
        if (sub_done) begin
          if (!enable) begin
            state_nxt = IDLE;
          end else if (need_cnt != '0) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = MAC;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_resample_mac_sequencer.sv
// Self-checking bench for resample_mac_sequencer with L=3, M=2, 12 taps, including a MAC/delay-line model.
module tb_resample_mac_sequencer;

  localparam int NT  = 12;
  localparam int L   = 3;
  localparam int M   = 2;
  localparam int TPP = NT / L;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_en, mac_en, phase_min, out_valid, busy;
  logic [1:0] rd_offset;
  logic [3:0] coeff_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  resample_mac_sequencer #(
    .NUMBER_OF_TAPS (NT),
    .INTERP_L       (L),
    .DECIM_M        (M)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .rd_offset  (rd_offset),
    .coeff_addr (coeff_addr),
    .mac_en     (mac_en),
    .phase_min  (phase_min),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  // Surrounding datapath: delay line, coefficient store and the shared MAC.
  int dl [TPP];
  int coef [NT];
  int pushes = 0;
  int acc = 0;
  int filter_out = 0;

  initial begin
    for (int a = 0; a < NT; a++) coef[a] = 2 * a - 7;
  end

  always @(posedge clk) begin
    if (wr_en) begin
      for (int i = TPP - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0]  <= pushes * 5 + 3;
      pushes <= pushes + 1;
    end
    if (mac_en) acc <= (phase_min ? 0 : acc) + dl[rd_offset] * coef[coeff_addr];
    if (phase_min) filter_out <= acc;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic iv);
    @(posedge clk);
    #1;
    enable   = en;
    in_valid = iv;
  endtask

  // Output n uses phase (n*M) mod L and needs floor(n*M/L)+1 inputs consumed in total.
  int n_out = 0;
  int tap = 0;
  int cyc = 0;
  int push_base = 0;
  int last_tap_cyc = -100;
  int base_log [16];
  int in_log [16];
  int out_cyc [16];
  int tap0_cyc [16];
  int res_log [16];
  int addr0_log [4];

  function automatic int expected_dot(input int base);
    int s = 0;
    for (int k = 0; k < TPP; k++) s += coef[base + k * L] * dl[k];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_outputs",
                  int'({in_ready, wr_en, rd_offset, coeff_addr, mac_en, phase_min, out_valid, busy}), 0);
      n_out        = 0;
      tap          = 0;
      push_base    = pushes;
      last_tap_cyc = -100;
    end else begin
      cyc++;
      checkOutput("wr_en_rule", int'(wr_en), int'(in_valid & in_ready));
      if (mac_en) begin
        if (tap == 0) begin
          checkOutput("inputs_before_output", pushes - push_base, (n_out * M) / L + 1);
          base_log[n_out % 16] = int'(coeff_addr);
          in_log[n_out % 16]   = pushes - push_base;
          tap0_cyc[n_out % 16] = cyc;
        end
        checkOutput("coeff_addr", int'(coeff_addr), (n_out * M) % L + tap * L);
        checkOutput("rd_offset", int'(rd_offset), tap);
        checkOutput("phase_min_tap", int'(phase_min), (tap == 0) ? 1 : 0);
        checkOutput("in_ready_in_mac", int'(in_ready), 0);
        if (n_out == 0 && tap < 4) addr0_log[tap] = int'(coeff_addr);
        tap++;
        last_tap_cyc = cyc;
      end else if (phase_min) begin
        checkOutput("taps_before_flush", tap, TPP);
      end
      if (out_valid) begin
        checkOutput("out_valid_latency", cyc - last_tap_cyc, 2);
        checkOutput("filter_out", filter_out, expected_dot((n_out * M) % L));
        res_log[n_out % 16] = filter_out;
        out_cyc[n_out % 16] = cyc;
        n_out++;
        tap = 0;
      end
    end
  end

  task automatic waitOut(input int target, input string name);
    int c = 0;
    while (n_out < target && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (n_out < target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout_%s: outputs %0d, required %0d", name, n_out, target);
    end
  endtask

  task automatic waitCond(input int which, input string name);
    int c = 0;
    logic hit = 1'b0;
    while (!hit && c < 500) begin
      @(negedge clk);
      c++;
      case (which)
        0:       hit = in_ready;
        1:       hit = mac_en && (rd_offset == 2'd2);
        default: hit = mac_en;
      endcase
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout_%s: condition not seen", name);
    end
  endtask

  initial begin
    $display("[TB] resample_mac_sequencer bench, L=%0d M=%0d taps=%0d", L, M, NT);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Free-running outputs with input always available.
    applyStimulus(1'b1, 1'b1);
    waitOut(4, "run4");
    #2 in_valid = 1'b0;
    waitOut(5, "run5");
    checkOutput("first_addr0", addr0_log[0], 0);
    checkOutput("first_addr1", addr0_log[1], 3);
    checkOutput("first_addr2", addr0_log[2], 6);
    checkOutput("first_addr3", addr0_log[3], 9);
    checkOutput("base0", base_log[0], 0);
    checkOutput("base1", base_log[1], 2);
    checkOutput("base2", base_log[2], 1);
    checkOutput("base3", base_log[3], 0);
    checkOutput("base4", base_log[4], 2);
    checkOutput("inputs0", in_log[0], 1);
    checkOutput("inputs1", in_log[1] - in_log[0], 0);
    checkOutput("inputs2", in_log[2] - in_log[1], 1);
    checkOutput("inputs3", in_log[3] - in_log[2], 1);
    checkOutput("inputs4", in_log[4] - in_log[3], 0);
    checkOutput("dot0", res_log[0], -21);
    checkOutput("dot1", res_log[1], -9);
    checkOutput("dot2", res_log[2], -37);
    checkOutput("gap_no_sub", tap0_cyc[1] - out_cyc[0], 1);
    checkOutput("gap_one_sub", tap0_cyc[2] - out_cyc[1], 3);
    checkOutput("output_period", tap0_cyc[1] - tap0_cyc[0], TPP + 2);

    // Upstream stalls while the sequencer is waiting in FETCH.
    waitCond(0, "fetch");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_in_ready", int'(in_ready), 1);
      checkOutput("stall_mac_en", int'(mac_en), 0);
      checkOutput("stall_out_valid", int'(out_valid), 0);
      @(negedge clk);
    end
    #2 in_valid = 1'b1;
    #1 checkOutput("stall_accept_wr_en", int'(wr_en), 1);
    @(negedge clk);
    checkOutput("resume_mac_en", int'(mac_en), 1);
    checkOutput("resume_phase_min", int'(phase_min), 1);
    checkOutput("resume_rd_offset", int'(rd_offset), 0);
    waitOut(6, "after_stall");

    // Asynchronous reset in the middle of tap 2.
    waitCond(1, "tap2");
    #2 rst_n = 1'b0;
    #1 checkOutput("midreset_outputs",
                   int'({in_ready, wr_en, rd_offset, coeff_addr, mac_en, phase_min, out_valid, busy}), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    waitOut(1, "post_reset");
    checkOutput("post_reset_base", base_log[0], 0);
    checkOutput("post_reset_inputs", in_log[0], 1);

    // Drop enable during the next output's MAC, then resume.
    waitCond(2, "mac_for_disable");
    #2 enable = 1'b0;
    waitOut(2, "disable_complete");
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_in_ready", int'(in_ready), 0);
    repeat (4) @(negedge clk);
    checkOutput("idle_still_busy", int'(busy), 0);
    checkOutput("idle_no_mac", int'(mac_en), 0);
    applyStimulus(1'b1, 1'b1);
    waitOut(3, "resume");
    checkOutput("resume_base", base_log[2], 1);
    checkOutput("resume_inputs", in_log[2] - in_log[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/resample_mac_sequencer.md
Name: resample_mac_sequencer

Overview:
- Control FSM for the polyphase rational resampler (L/M). Sequences the single shared MAC datapath (`compute`), the sample delay line and the coefficient store.
- Per output sample it:
  - pulls the required new input samples into the delay line;
  - issues TAPS_PER_PHASE MAC cycles with matching sample offset and coefficient address;
  - issues a flush pulse so the accumulated result is latched;
  - flags the output valid.

Parameters:
- NUMBER_OF_TAPS, 64, total prototype filter taps; must be a multiple of INTERP_L.
- INTERP_L, 4, interpolation factor L (number of polyphase branches), ≥1.
- DECIM_M, 3, decimation factor M, ≥1.
- TAPS_PER_PHASE, NUMBER_OF_TAPS/INTERP_L, derived; MAC cycles per output.
- PHASE_W, clog2(INTERP_L) min 1, derived.
- TAP_W, clog2(TAPS_PER_PHASE) min 1, derived.
- CADDR_W, clog2(NUMBER_OF_TAPS), derived.
- NEED_W, clog2(DECIM_M/INTERP_L+2), derived; width of the pending-input counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, run request; sampled at output boundaries.
- in_valid, input, 1, upstream sample available.
- in_ready, output, 1, sequencer will accept a sample this cycle.
- wr_en, output, 1, delay-line push strobe; equals in_valid & in_ready.
- rd_offset, output, TAP_W, delay-line tap select (0 = newest sample).
- coeff_addr, output, CADDR_W, coefficient store address.
- mac_en, output, 1, drives `compute` clk_enable.
- phase_min, output, 1, drives `compute` phase_min (accumulator restart / result latch).
- out_valid, output, 1, one-cycle pulse; `compute` filter_out is valid this cycle.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, phase=0, need_cnt=1, k=0.
  - All outputs 0: in_ready, wr_en, rd_offset, coeff_addr, mac_en, phase_min, out_valid, busy.
  - Reset mid-operation abandons the current output; no out_valid is produced for it.
- States: IDLE, FETCH, MAC, FLUSH, ADVANCE.
- IDLE:
  - enable=1 → FETCH if need_cnt>0, else MAC.
- FETCH:
  - in_ready=1; each in_valid cycle pulses wr_en and decrements need_cnt.
  - When need_cnt reaches 0 (the accepting cycle counts) → MAC with k=0 next cycle.
- MAC:
  - Lasts exactly TAPS_PER_PHASE cycles. mac_en=1; rd_offset=k; coeff_addr=phase+k*INTERP_L, formed incrementally by adding INTERP_L, no multiplier.
  - phase_min=1 only at k=0. k increments each cycle.
  - Exit: after k=TAPS_PER_PHASE-1 → FLUSH.
- FLUSH:
  - One cycle: phase_min=1, mac_en=0; latches the complete sum into the accumulator output register.
  - phase ← phase+DECIM_M, width PHASE_W+NEED_W+1.
  - → ADVANCE.
  - out_valid is registered from FLUSH, so it pulses the cycle after FLUSH (2 cycles after the last tap cycle).
- ADVANCE:
  - While phase ≥ INTERP_L: phase −= INTERP_L, need_cnt += 1, one subtraction per cycle.
  - When phase < INTERP_L:
    - enable=0 → IDLE, keeping phase and need_cnt;
    - need_cnt>0 → FETCH;
    - otherwise → MAC.
- Second phase_min at the next MAC k=0 re-latches an unchanged accumulator (mac_en held 0 since FLUSH). filter_out is stable; no second out_valid.
- enable deassert mid-output: the current output completes through FLUSH/ADVANCE (out_valid still pulses), then IDLE.
- in_valid outside FETCH is ignored (in_ready=0, wr_en=0).
- No wrap hazards: phase < INTERP_L holds at every MAC, so coeff_addr < NUMBER_OF_TAPS.
- Throughput: TAPS_PER_PHASE+2+(subtractions)+(input wait) cycles per output.

Decomposition:
- Package resample_pkg holds:
  - state enum (IDLE, FETCH, MAC, FLUSH, ADVANCE);
  - clog2-based width localparams;
  - elaboration check that NUMBER_OF_TAPS % INTERP_L == 0.
- One sub-module, resample_phase_stepper: holds phase and need_cnt and performs the FLUSH add and the ADVANCE subtraction/increment. Inputs step and sub_en; outputs phase, need_cnt, sub_done.
- Tap counter, address generation and FSM stay in the top.

Test Plan (L=3, M=2, NUMBER_OF_TAPS=12, TAPS_PER_PHASE=4):
- Reset then enable=1, in_valid=1 constant → one wr_en, then coeff_addr 0,3,6,9 with rd_offset 0..3 and mac_en=1. phase_min high on the first tap and on FLUSH; out_valid 2 cycles after the tap at address 9.
- Phase sequence across outputs → coeff base 0, 2, 1, 0, 2. Inputs consumed before each output: 1, 0, 1, 1, 0. A phase-2 output is followed by ADVANCE with one subtraction (4→1).
- in_valid low during FETCH for 5 cycles → in_ready held 1, mac_en=0, no out_valid; MAC resumes the cycle after the accepting cycle.
- Drive `compute` with known samples and coefficients → filter_out at out_valid equals the 4-tap dot product. No extra out_valid on the next phase_min.
- rst_n low during MAC tap 2 → all outputs 0 immediately. After release and enable, the first output restarts at phase 0 with need 1.
- enable dropped during MAC → current output completes with out_valid, then busy=0 and in_ready=0. Re-enable resumes at the saved phase.
